axi_ram_slave: RTL and testbench
================================

// Module: axi_ram_slave
// PURPOSE
// - AXI4 subordinate (responder) backed by on-chip RAM; terminates one crossbar slave port (AW/W/B, AR/R).
// - Independent write and read engines; one outstanding burst per direction; data fixed at 64 bit.
// PARAMETERS
// - ID_W    8    width of AWID/BID/ARID/RID
// - ADDR_W  32   byte-address width
// - DEPTH   1024 RAM depth in 64-bit words (power of 2); IDX_W = log2(DEPTH)
// PORTS
// - aclk       in  1      clock, all logic rising-edge
// - aresetn    in  1      synchronous active-low reset
// - s_awid     in  ID_W   write burst ID
// - s_awaddr   in  ADDR_W write start byte address
// - s_awlen    in  8      write beats minus 1
// - s_awvalid  in  1      AW valid
// - s_awready  out 1      AW ready
// - s_wdata    in  64     write data
// - s_wstrb    in  8      byte enables
// - s_wlast    in  1      last write beat (informational)
// - s_wvalid   in  1      W valid
// - s_wready   out 1      W ready
// - s_bid      out ID_W   echoed AWID
// - s_bresp    out 2      00 OKAY / 10 SLVERR
// - s_bvalid   out 1      B valid
// - s_bready   in  1      B ready
// - s_arid     in  ID_W   read burst ID
// - s_araddr   in  ADDR_W read start byte address
// - s_arlen    in  8      read beats minus 1
// - s_arvalid  in  1      AR valid
// - s_arready  out 1      AR ready
// - s_rid      out ID_W   echoed ARID
// - s_rdata    out 64     read data
// - s_rresp    out 2      00 OKAY / 10 SLVERR
// - s_rlast    out 1      last read beat
// - s_rvalid   out 1      R valid
// - s_rready   in  1      R ready
// BEHAVIOUR
// - Reset (aresetn=0 at edge): all outputs 0, both FSMs to IDLE, beat counters 0; RAM not cleared. Mid-burst reset aborts burst, no B/R issued.
// - All bursts INCR, full 64-bit beats (size/burst not ported); word index = addr[IDX_W+2:3], +1 per beat, wraps modulo DEPTH.
// - Write FSM W_IDLE->W_DATA->W_RESP->W_IDLE. W_IDLE: awready=1; AW handshake latches id/addr/len. W_DATA: wready=1; each W handshake writes bytes where wstrb=1; beat count==awlen ends burst (wlast ignored) -> W_RESP. W_RESP: bvalid=1, bid=latched id, hold stable until bready; then W_IDLE. awready=0 outside W_IDLE.
// - Read FSM R_IDLE->R_FETCH->R_DATA. R_IDLE: arready=1; AR handshake latches id/addr/len. R_FETCH: registered RAM read, 1 cycle, rvalid=0. R_DATA: rvalid=1, rdata/rid/rresp/rlast stable until rready; rlast=1 when beat count==arlen. Handshake: last -> R_IDLE, else -> R_FETCH. First rvalid 2 cycles after AR handshake; 1 beat per 2 cycles.
// - Same-cycle write and read fetch of one word: read returns old data.
// CONFIGURATION
// - AXI_RAM_ERR_DECODE_EN defined: burst whose start addr has any bit above IDX_W+2 set -> writes suppressed, bresp=10; reads rdata=0, rresp=10 every beat. Handshake timing unchanged.
// - Undefined: upper address bits ignored (aliasing), bresp/rresp always 00.
// TESTING
// - AW id=5 addr=0x10 len=0, W 0x1122334455667788 strb=FF -> B id=5 resp=00; AR 0x10 len=0 -> rdata same, rlast=1, rresp=00.
// - AW 0x0 len=3 beats A0..A3, beat2 strb=0F over prior FFFF..FF -> readback beat2 = FFFFFFFF_<A2 low 32>, others intact, rlast only on beat 4.
// - AR len=7 with rready low 5 cycles mid-burst -> rvalid/rdata/rlast stable, 8 beats delivered, none lost.
// - bready low 10 cycles after last W -> bvalid held, awready=0 throughout; awready=1 cycle after B handshake.
// - DEPTH=256, write to 0x800: with macro bresp=10 and word 0 unchanged; without macro word 0 overwritten.
// - aresetn low 1 cycle during W_DATA beat 2 -> next cycle bvalid=0, wready=0, awready=1, new burst completes normally.

Source files
------------

// File: rtl/axi_ram_slave_if.sv
// AXI4 slave-port bundle (AW/W/B, AR/R) for the RAM responder.
// The master modport is the crossbar/initiator side. The slave modport is the RAM side.
// Ports:
//   AW: s_awid, s_awaddr, s_awlen, s_awvalid / s_awready
//   W : s_wdata, s_wstrb, s_wlast, s_wvalid / s_wready
//   B : s_bid, s_bresp, s_bvalid / s_bready
//   AR: s_arid, s_araddr, s_arlen, s_arvalid / s_arready
//   R : s_rid, s_rdata, s_rresp, s_rlast, s_rvalid / s_rready
interface axi_ram_slave_if #(
    parameter int unsigned ID_W   = 8,
    parameter int unsigned ADDR_W = 32
);
    localparam int unsigned DATA_W = 64;
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned LEN_W  = 8;

    logic [ID_W-1:0]   s_awid;
    logic [ADDR_W-1:0] s_awaddr;
    logic [LEN_W-1:0]  s_awlen;
    logic              s_awvalid;
    logic              s_awready;

    logic [DATA_W-1:0] s_wdata;
    logic [STRB_W-1:0] s_wstrb;
    logic              s_wlast;
    logic              s_wvalid;
    logic              s_wready;

    logic [ID_W-1:0]   s_bid;
    logic [1:0]        s_bresp;
    logic              s_bvalid;
    logic              s_bready;

    logic [ID_W-1:0]   s_arid;
    logic [ADDR_W-1:0] s_araddr;
    logic [LEN_W-1:0]  s_arlen;
    logic              s_arvalid;
    logic              s_arready;

    logic [ID_W-1:0]   s_rid;
    logic [DATA_W-1:0] s_rdata;
    logic [1:0]        s_rresp;
    logic              s_rlast;
    logic              s_rvalid;
    logic              s_rready;

    modport master (
        output s_awid, s_awaddr, s_awlen, s_awvalid,
        input  s_awready,
        output s_wdata, s_wstrb, s_wlast, s_wvalid,
        input  s_wready,
        input  s_bid, s_bresp, s_bvalid,
        output s_bready,
        output s_arid, s_araddr, s_arlen, s_arvalid,
        input  s_arready,
        input  s_rid, s_rdata, s_rresp, s_rlast, s_rvalid,
        output s_rready
    );

    modport slave (
        input  s_awid, s_awaddr, s_awlen, s_awvalid,
        output s_awready,
        input  s_wdata, s_wstrb, s_wlast, s_wvalid,
        output s_wready,
        output s_bid, s_bresp, s_bvalid,
        input  s_bready,
        input  s_arid, s_araddr, s_arlen, s_arvalid,
        output s_arready,
        output s_rid, s_rdata, s_rresp, s_rlast, s_rvalid,
        input  s_rready
    );
endinterface

// File: rtl/axi_ram_slave.sv
// AXI4 responder backed by on-chip RAM (64-bit words, INCR bursts only).
// It has independent write and read engines, and each allows one outstanding burst.
// Ports:
//   aclk     - clock, rising edge
//   aresetn  - synchronous active-low reset (RAM contents are kept)
//   s        - axi_ram_slave_if.slave bundle (AW/W/B/AR/R)
// Optional feature: define AXI_RAM_ERR_DECODE_EN to reject bursts whose start
// address lies above the RAM.
//   - Writes of a rejected burst are dropped and B returns SLVERR.
//   - Reads of a rejected burst return zero data with SLVERR on every beat.
// Without the macro, the upper address bits alias onto the RAM.
module axi_ram_slave #(
    parameter int unsigned ID_W   = 8,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DEPTH  = 1024
) (
    input  logic           aclk,
    input  logic           aresetn,
    axi_ram_slave_if.slave s
);
    localparam int unsigned DATA_W = 64;
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned LEN_W  = 8;
    localparam int unsigned IDX_W  = $clog2(DEPTH);
    localparam int unsigned HI_LSB = IDX_W + 3;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    // write engine state
    w_state_t          w_state;
    logic [ID_W-1:0]   w_id;
    logic [IDX_W-1:0]  w_idx;
    logic [LEN_W-1:0]  w_len;
    logic [LEN_W-1:0]  w_cnt;
    logic              w_err;
    logic              awready_q;
    logic              wready_q;
    logic              bvalid_q;
    logic [ID_W-1:0]   bid_q;
    logic [1:0]        bresp_q;

    // read engine state
    r_state_t          r_state;
    logic [ID_W-1:0]   r_id;
    logic [IDX_W-1:0]  r_idx;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_cnt;
    logic              r_err;
    logic              arready_q;
    logic              rvalid_q;
    logic [ID_W-1:0]   rid_q;
    logic [DATA_W-1:0] rdata_q;
    logic [1:0]        rresp_q;
    logic              rlast_q;

    logic              aw_err_c;
    logic              ar_err_c;
    logic              w_beat_c;

    // Out-of-range decode of the start address
`ifdef AXI_RAM_ERR_DECODE_EN
    assign aw_err_c = |(s.s_awaddr >> HI_LSB);
    assign ar_err_c = |(s.s_araddr >> HI_LSB);
`else
    assign aw_err_c = 1'b0;
    assign ar_err_c = 1'b0;
`endif

    // wlast and the byte-offset address bits are not needed by this design
    logic unused_ok;
    assign unused_ok = ^{s.s_wlast, s.s_awaddr, s.s_araddr};

    assign w_beat_c = (w_state == W_DATA) && wready_q && s.s_wvalid;

    // RAM write port: byte-enabled, suppressed for rejected bursts and in reset
    always_ff @(posedge aclk) begin
        if (aresetn && w_beat_c && !w_err) begin
            for (int b = 0; b < int'(STRB_W); b++) begin
                if (s.s_wstrb[b]) begin
                    mem[w_idx][b*8 +: 8] <= s.s_wdata[b*8 +: 8];
                end
            end
        end
    end

    // Write engine: AW accept -> data beats -> B response
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            w_state   <= W_IDLE;
            w_id      <= '0;
            w_idx     <= '0;
            w_len     <= '0;
            w_cnt     <= '0;
            w_err     <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= '0;
            bresp_q   <= RESP_OKAY;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (s.s_awvalid && awready_q) begin
                        w_id      <= s.s_awid;
                        w_idx     <= s.s_awaddr[IDX_W+2:3];
                        w_len     <= s.s_awlen;
                        w_cnt     <= '0;
                        w_err     <= aw_err_c;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b1;
                        w_state   <= W_DATA;
                    end else begin
                        awready_q <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (s.s_wvalid) begin
                        w_idx <= w_idx + IDX_W'(1);
                        // beat count alone terminates the burst; wlast is not trusted
                        if (w_cnt == w_len) begin
                            wready_q <= 1'b0;
                            bvalid_q <= 1'b1;
                            bid_q    <= w_id;
                            bresp_q  <= w_err ? RESP_SLVERR : RESP_OKAY;
                            w_state  <= W_RESP;
                        end else begin
                            w_cnt <= w_cnt + LEN_W'(1);
                        end
                    end
                end
                W_RESP: begin
                    if (s.s_bready) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        w_state   <= W_IDLE;
                    end
                end
                default: begin
                    w_state <= W_IDLE;
                end
            endcase
        end
    end

    // Read engine: AR accept -> (fetch -> data beat) per beat
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state   <= R_IDLE;
            r_id      <= '0;
            r_idx     <= '0;
            r_len     <= '0;
            r_cnt     <= '0;
            r_err     <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rid_q     <= '0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            rlast_q   <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (s.s_arvalid && arready_q) begin
                        r_id      <= s.s_arid;
                        r_idx     <= s.s_araddr[IDX_W+2:3];
                        r_len     <= s.s_arlen;
                        r_cnt     <= '0;
                        r_err     <= ar_err_c;
                        arready_q <= 1'b0;
                        r_state   <= R_FETCH;
                    end else begin
                        arready_q <= 1'b1;
                    end
                end
                R_FETCH: begin
                    // registered read; a same-cycle write to this word yields the old data
                    rdata_q  <= r_err ? '0 : mem[r_idx];
                    rid_q    <= r_id;
                    rresp_q  <= r_err ? RESP_SLVERR : RESP_OKAY;
                    rlast_q  <= (r_cnt == r_len);
                    rvalid_q <= 1'b1;
                    r_state  <= R_DATA;
                end
                R_DATA: begin
                    if (s.s_rready) begin
                        rvalid_q <= 1'b0;
                        rlast_q  <= 1'b0;
                        if (rlast_q) begin
                            arready_q <= 1'b1;
                            r_state   <= R_IDLE;
                        end else begin
                            r_cnt   <= r_cnt + LEN_W'(1);
                            r_idx   <= r_idx + IDX_W'(1);
                            r_state <= R_FETCH;
                        end
                    end
                end
                default: begin
                    r_state <= R_IDLE;
                end
            endcase
        end
    end

    assign s.s_awready = awready_q;
    assign s.s_wready  = wready_q;
    assign s.s_bvalid  = bvalid_q;
    assign s.s_bid     = bid_q;
    assign s.s_bresp   = bresp_q;
    assign s.s_arready = arready_q;
    assign s.s_rvalid  = rvalid_q;
    assign s.s_rid     = rid_q;
    assign s.s_rdata   = rdata_q;
    assign s.s_rresp   = rresp_q;
    assign s.s_rlast   = rlast_q;

endmodule

// File: tb/tb_axi_ram_slave.sv
// Scoreboard bench for axi_ram_slave (DEPTH=256); follows AXI_RAM_ERR_DECODE_EN if defined.
module tb_axi_ram_slave;
    localparam int unsigned ID_W   = 8;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DEPTH  = 256;
    localparam int unsigned HI_LSB = $clog2(DEPTH) + 3;
    localparam int          TMO    = 200;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    axi_ram_slave_if #(.ID_W(ID_W), .ADDR_W(ADDR_W)) bus ();

    axi_ram_slave #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .s       (bus)
    );

    typedef struct {
        logic [7:0] id;
        logic [1:0] resp;
    } b_exp_t;

    typedef struct {
        logic [7:0]  id;
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } r_exp_t;

    b_exp_t b_q [$];
    r_exp_t r_q [$];

    logic [63:0] ref_mem [DEPTH];
    logic [63:0] beat_data [16];
    logic [7:0]  beat_strb [16];

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic addr_err(input logic [31:0] a);
`ifdef AXI_RAM_ERR_DECODE_EN
        return (a >> HI_LSB) != 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int unsigned word_idx(input logic [31:0] a, input int beat);
        return ((a >> 3) + beat) % DEPTH;
    endfunction

    task automatic model_write(input logic [31:0] a, input int beat, input logic [63:0] d, input logic [7:0] st);
        int unsigned k;
        if (!addr_err(a)) begin
            k = word_idx(a, beat);
            for (int b = 0; b < 8; b++)
                if (st[b]) ref_mem[k][b*8 +: 8] = d[b*8 +: 8];
        end
    endtask

    // Handshake monitor: compare every B/R transfer against the queued expectation
    b_exp_t be;
    r_exp_t re;
    always @(negedge aclk) begin
        if (aresetn && bus.s_bvalid && bus.s_bready) begin
            if (b_q.size() == 0) check_val("b_unexpected", 64'd1, 64'd0);
            else begin
                be = b_q.pop_front();
                check_val("bid", 64'(bus.s_bid), 64'(be.id));
                check_val("bresp", 64'(bus.s_bresp), 64'(be.resp));
            end
        end
        if (aresetn && bus.s_rvalid && bus.s_rready) begin
            if (r_q.size() == 0) check_val("r_unexpected", 64'd1, 64'd0);
            else begin
                re = r_q.pop_front();
                check_val("rid", 64'(bus.s_rid), 64'(re.id));
                check_val("rdata", bus.s_rdata, re.data);
                check_val("rresp", 64'(bus.s_rresp), 64'(re.resp));
                check_val("rlast", 64'(bus.s_rlast), 64'(re.last));
            end
        end
    end

    task automatic aw_send(input logic [7:0] id, input logic [31:0] a, input int len);
        bit ok = 0;
        bus.s_awid = id; bus.s_awaddr = a; bus.s_awlen = 8'(len); bus.s_awvalid = 1'b1;
        for (int i = 0; i < TMO && !ok; i++) begin
            @(negedge aclk);
            if (bus.s_awready) ok = 1;
        end
        if (!ok) check_val("aw_timeout", 64'd0, 64'd1);
        @(posedge aclk); #1;
        bus.s_awvalid = 1'b0;
    endtask

    task automatic w_send(input logic [63:0] d, input logic [7:0] st, input logic last);
        bit ok = 0;
        bus.s_wdata = d; bus.s_wstrb = st; bus.s_wlast = last; bus.s_wvalid = 1'b1;
        for (int i = 0; i < TMO && !ok; i++) begin
            @(negedge aclk);
            if (bus.s_wready) ok = 1;
        end
        if (!ok) check_val("w_timeout", 64'd0, 64'd1);
        @(posedge aclk); #1;
        bus.s_wvalid = 1'b0; bus.s_wlast = 1'b0;
    endtask

    task automatic ar_send(input logic [7:0] id, input logic [31:0] a, input int len);
        bit ok = 0;
        bus.s_arid = id; bus.s_araddr = a; bus.s_arlen = 8'(len); bus.s_arvalid = 1'b1;
        for (int i = 0; i < TMO && !ok; i++) begin
            @(negedge aclk);
            if (bus.s_arready) ok = 1;
        end
        if (!ok) check_val("ar_timeout", 64'd0, 64'd1);
        @(posedge aclk); #1;
        bus.s_arvalid = 1'b0;
    endtask

    task automatic write_burst(input logic [7:0] id, input logic [31:0] a, input int len);
        b_q.push_back('{id: id, resp: addr_err(a) ? 2'b10 : 2'b00});
        aw_send(id, a, len);
        for (int i = 0; i <= len; i++) begin
            w_send(beat_data[i], beat_strb[i], i == len);
            model_write(a, i, beat_data[i], beat_strb[i]);
        end
    endtask

    task automatic read_issue(input logic [7:0] id, input logic [31:0] a, input int len);
        r_exp_t e;
        for (int i = 0; i <= len; i++) begin
            e.id   = id;
            e.data = addr_err(a) ? 64'd0 : ref_mem[word_idx(a, i)];
            e.resp = addr_err(a) ? 2'b10 : 2'b00;
            e.last = (i == len);
            r_q.push_back(e);
        end
        ar_send(id, a, len);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((b_q.size() != 0 || r_q.size() != 0) && n < 4 * TMO) begin
            @(posedge aclk);
            n++;
        end
        if (b_q.size() != 0 || r_q.size() != 0) begin
            check_val("drain_timeout", 64'(b_q.size() + r_q.size()), 64'd0);
            b_q.delete();
            r_q.delete();
        end
        @(posedge aclk); #1;
    endtask

    logic [63:0] cap_data;
    logic        cap_last;
    bit          seen;

    initial begin
        bus.s_awid = '0; bus.s_awaddr = '0; bus.s_awlen = '0; bus.s_awvalid = 1'b0;
        bus.s_wdata = '0; bus.s_wstrb = '0; bus.s_wlast = 1'b0; bus.s_wvalid = 1'b0;
        bus.s_bready = 1'b1;
        bus.s_arid = '0; bus.s_araddr = '0; bus.s_arlen = '0; bus.s_arvalid = 1'b0;
        bus.s_rready = 1'b1;
        for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = '0;

        // reset: every output low while held
        aresetn = 1'b0;
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        check_val("rst_awready", 64'(bus.s_awready), 64'd0);
        check_val("rst_wready",  64'(bus.s_wready),  64'd0);
        check_val("rst_bvalid",  64'(bus.s_bvalid),  64'd0);
        check_val("rst_arready", 64'(bus.s_arready), 64'd0);
        check_val("rst_rvalid",  64'(bus.s_rvalid),  64'd0);
        check_val("rst_rlast",   64'(bus.s_rlast),   64'd0);
        check_val("rst_rdata",   bus.s_rdata,        64'd0);
        @(posedge aclk); #1;
        aresetn = 1'b1;
        @(posedge aclk); #1;
        check_val("idle_awready", 64'(bus.s_awready), 64'd1);
        check_val("idle_arready", 64'(bus.s_arready), 64'd1);

        // single-beat write and readback
        beat_data[0] = 64'h1122334455667788; beat_strb[0] = 8'hFF;
        write_burst(8'd5, 32'h10, 0);
        wait_drain();
        read_issue(8'd6, 32'h10, 0);
        wait_drain();

        // 4-beat burst with a partial strobe on beat 2 over an all-ones background
        for (int i = 0; i < 4; i++) begin beat_data[i] = '1; beat_strb[i] = 8'hFF; end
        write_burst(8'd1, 32'h0, 3);
        wait_drain();
        for (int i = 0; i < 4; i++) begin
            beat_data[i] = 64'hA0A0_0000_0000_0000 + 64'(i) * 64'h0101_0101_1111_1111;
            beat_strb[i] = 8'hFF;
        end
        beat_strb[2] = 8'h0F;
        write_burst(8'd2, 32'h0, 3);
        wait_drain();
        read_issue(8'd3, 32'h0, 3);
        wait_drain();

        // 8-beat read with a 5-cycle rready stall in the middle
        for (int i = 0; i < 8; i++) begin
            beat_data[i] = {32'hC0DE_0000 + 32'(i), $urandom};
            beat_strb[i] = 8'hFF;
        end
        write_burst(8'd7, 32'h100, 7);
        wait_drain();
        read_issue(8'd8, 32'h100, 7);
        for (int n = 0; n < TMO && r_q.size() > 5; n++) @(posedge aclk);
        #1;
        bus.s_rready = 1'b0;
        seen = 0;
        for (int n = 0; n < TMO && !seen; n++) begin
            @(negedge aclk);
            if (bus.s_rvalid) seen = 1;
        end
        if (!seen) check_val("stall_rvalid_timeout", 64'd0, 64'd1);
        cap_data = bus.s_rdata;
        cap_last = bus.s_rlast;
        for (int n = 0; n < 5; n++) begin
            @(negedge aclk);
            check_val("stall_rvalid", 64'(bus.s_rvalid), 64'd1);
            check_val("stall_rdata",  bus.s_rdata,       cap_data);
            check_val("stall_rlast",  64'(bus.s_rlast),  64'(cap_last));
        end
        @(posedge aclk); #1;
        bus.s_rready = 1'b1;
        wait_drain();

        // B backpressure: bvalid held, no new AW accepted
        bus.s_bready = 1'b0;
        beat_data[0] = 64'h5555_6666_7777_8888; beat_data[1] = 64'h9999_AAAA_BBBB_CCCC;
        beat_strb[0] = 8'hFF; beat_strb[1] = 8'hFF;
        write_burst(8'd9, 32'h200, 1);
        seen = 0;
        for (int n = 0; n < TMO && !seen; n++) begin
            @(negedge aclk);
            if (bus.s_bvalid) seen = 1;
        end
        if (!seen) check_val("bvalid_timeout", 64'd0, 64'd1);
        for (int n = 0; n < 10; n++) begin
            @(negedge aclk);
            check_val("bhold_bvalid",  64'(bus.s_bvalid),  64'd1);
            check_val("bhold_awready", 64'(bus.s_awready), 64'd0);
            check_val("bhold_bid",     64'(bus.s_bid),     64'd9);
        end
        @(posedge aclk); #1;
        bus.s_bready = 1'b1;
        @(posedge aclk); #1;
        check_val("post_b_awready", 64'(bus.s_awready), 64'd1);
        wait_drain();

        // out-of-range start address (bit above the RAM index set)
        beat_data[0] = 64'hDEAD_BEEF_0BAD_F00D; beat_strb[0] = 8'hFF;
        write_burst(8'd10, 32'h800, 0);
        wait_drain();
        read_issue(8'd11, 32'h0, 0);
        wait_drain();
        read_issue(8'd12, 32'h800, 1);
        wait_drain();

        // reset during a write burst: no B, engines idle, then a clean burst
        aw_send(8'd13, 32'h40, 3);
        w_send(64'h0101_0101_0101_0101, 8'hFF, 1'b0);
        model_write(32'h40, 0, 64'h0101_0101_0101_0101, 8'hFF);
        w_send(64'h0202_0202_0202_0202, 8'hFF, 1'b0);
        model_write(32'h40, 1, 64'h0202_0202_0202_0202, 8'hFF);
        bus.s_wdata = 64'h0303_0303_0303_0303; bus.s_wstrb = 8'hFF; bus.s_wvalid = 1'b1;
        aresetn = 1'b0;
        @(posedge aclk); #1;
        aresetn = 1'b1;
        bus.s_wvalid = 1'b0;
        @(posedge aclk); #1;
        check_val("rst2_bvalid",  64'(bus.s_bvalid),  64'd0);
        check_val("rst2_wready",  64'(bus.s_wready),  64'd0);
        check_val("rst2_awready", 64'(bus.s_awready), 64'd1);
        for (int i = 0; i < 4; i++) begin
            beat_data[i] = 64'h4000_0000_0000_0000 | 64'(i * 7 + 1); beat_strb[i] = 8'hFF;
        end
        write_burst(8'd14, 32'h40, 3);
        wait_drain();
        read_issue(8'd15, 32'h40, 3);
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
